// File: rtl/writeback_unit.sv
// Result writeback: buffers ALU/load results, extends loads, round-robins one regfile write per cycle.
// Latency: an entry accepted at edge N is presented at the write port in cycle N+1 at the earliest.
// Backpressure: a source's ready follows its FIFO fullness; write_ready low holds the selected head in place.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Writeback front end: per-source FIFOs, round-robin arbitration, x0 writes dropped after popping.
// Latency: one cycle minimum from alu_*/ld_* acceptance to the write port; no combinational input path.
// Backpressure: x_ready = FIFO not full (forced low in reset); pops only when write_ready is high.
module writeback_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [63:0]      alu_value,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [63:0]      ld_data,
    input  logic [1:0]       ld_size,
    input  logic             ld_unsigned,
    output logic             write_enable,
    output logic [4:0]       write_register,
    output logic [63:0]      write_value,
    input  logic             write_ready,
    output logic [CNT_W-1:0] retired_count,
    output logic             idle
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] value;
    } alu_ent_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  size;
        logic        is_unsigned;
    } ld_ent_t;

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                           input logic uns);
        logic [63:0] r;
        case (size)
            2'd0:    r = {{56{~uns & d[7]}},  d[7:0]};
            2'd1:    r = {{48{~uns & d[15]}}, d[15:0]};
            2'd2:    r = {{32{~uns & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    alu_ent_t alu_in, alu_head;
    ld_ent_t  ld_in, ld_head;
    logic     alu_full, alu_empty, ld_full, ld_empty;
    logic     sel_alu, sel_ld, pop_alu, pop_ld;
    logic     rr_last_ld;

    assign alu_in    = '{rd: alu_rd, value: alu_value};
    assign ld_in     = '{rd: ld_rd, data: ld_data, size: ld_size, is_unsigned: ld_unsigned};
    assign alu_ready = !reset && !alu_full;
    assign ld_ready  = !reset && !ld_full;

    wb_fifo #(.W($bits(alu_ent_t)), .DEPTH(DEPTH)) u_alu_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (alu_valid && alu_ready),
        .push_dat (alu_in),
        .pop      (pop_alu),
        .head_dat (alu_head),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    wb_fifo #(.W($bits(ld_ent_t)), .DEPTH(DEPTH)) u_ld_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (ld_valid && ld_ready),
        .push_dat (ld_in),
        .pop      (pop_ld),
        .head_dat (ld_head),
        .full     (ld_full),
        .empty    (ld_empty)
    );

    // On a tie the source that did not win last goes next; reset suppresses any selection.
    assign sel_alu = !reset && !alu_empty && (ld_empty || rr_last_ld);
    assign sel_ld  = !reset && !ld_empty && (alu_empty || !rr_last_ld);
    assign pop_alu = sel_alu && write_ready;
    assign pop_ld  = sel_ld && write_ready;

    always_comb begin
        write_register = '0;
        write_value    = '0;
        if (sel_alu) begin
            write_register = alu_head.rd;
            write_value    = alu_head.value;
        end else if (sel_ld) begin
            write_register = ld_head.rd;
            write_value    = extend(ld_head.data, ld_head.size, ld_head.is_unsigned);
        end
    end

    assign write_enable = (pop_alu || pop_ld) && (write_register != 5'd0);
    assign idle         = alu_empty && ld_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_ld    <= 1'b1;
            retired_count <= '0;
        end else if (pop_alu || pop_ld) begin
            rr_last_ld    <= pop_ld;
            retired_count <= retired_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: load-extension vector table, directed corner sequences, random vs queue model.
module tb_writeback_unit;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_valid, alu_ready;
    logic [4:0]       alu_rd;
    logic [63:0]      alu_value;
    logic             ld_valid, ld_ready;
    logic [4:0]       ld_rd;
    logic [63:0]      ld_data;
    logic [1:0]       ld_size;
    logic             ld_unsigned;
    logic             write_enable;
    logic [4:0]       write_register;
    logic [63:0]      write_value;
    logic             write_ready;
    logic [CNT_W-1:0] retired_count;
    logic             idle;

    always #5 clk = ~clk;

    writeback_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_value      (alu_value),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_size        (ld_size),
        .ld_unsigned    (ld_unsigned),
        .write_enable   (write_enable),
        .write_register (write_register),
        .write_value    (write_value),
        .write_ready    (write_ready),
        .retired_count  (retired_count),
        .idle           (idle)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet();
        alu_valid = 0; alu_rd = 0; alu_value = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_size = 0; ld_unsigned = 0;
        write_ready = 1;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        tick();
        reset = 0;
    endtask

    function automatic logic [63:0] ref_extend(input logic [63:0] d, input int size, input bit uns);
        logic [63:0] mask, v;
        int nb;
        if (size == 3) return d;
        nb   = 8 << size;
        mask = (64'd1 << nb) - 64'd1;
        v    = d & mask;
        if (!uns && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  rd;
        logic [63:0] exp_value;
    } ld_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] v;
    } ent_t;

    ld_vec_t vecs[8];
    ent_t    aq[$];
    ent_t    lq[$];

    initial begin
        vecs[0] = '{64'h80, 2'd0, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{64'h80, 2'd0, 1'b1, 5'd3, 64'h80};
        vecs[2] = '{64'h8000_0000, 2'd2, 1'b0, 5'd4, 64'hFFFF_FFFF_8000_0000};
        vecs[3] = '{64'h7FFF, 2'd1, 1'b0, 5'd5, 64'h7FFF};
        vecs[4] = '{64'hFFFF_FF12, 2'd0, 1'b0, 5'd6, 64'h12};
        vecs[5] = '{64'h1234_8001, 2'd1, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_8001};
        vecs[6] = '{64'hDEAD_BEEF_8765_4321, 2'd2, 1'b1, 5'd8, 64'h8765_4321};
        vecs[7] = '{64'h8123_4567_89AB_CDEF, 2'd3, 1'b0, 5'd31, 64'h8123_4567_89AB_CDEF};

        // Reset behaviour
        quiet();
        reset = 1;
        settle();
        chk("ready_in_reset_alu", alu_ready, 0);
        chk("ready_in_reset_ld", ld_ready, 0);
        chk("we_in_reset", write_enable, 0);
        tick();
        reset = 0;
        settle();
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_we", write_enable, 0);
        chk("rst_wreg", write_register, 0);
        chk("rst_wval", write_value, 0);
        chk("rst_retired", retired_count, 0);
        chk("rst_idle", idle, 1);

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_value = 64'h1234;
        settle();
        chk("alu1_no_comb_path", write_enable, 0);
        tick();
        quiet();
        settle();
        chk("alu1_idle_busy", idle, 0);
        chk("alu1_we", write_enable, 1);
        chk("alu1_wreg", write_register, 5);
        chk("alu1_wval", write_value, 64'h1234);
        tick();
        settle();
        chk("alu1_retired", retired_count, 1);
        chk("alu1_idle", idle, 1);
        chk("alu1_we_after", write_enable, 0);

        // Simultaneous ALU and load: ALU wins the first tie
        do_reset();
        alu_valid = 1; alu_rd = 1; alu_value = 64'hA;
        ld_valid = 1; ld_rd = 2; ld_data = 64'hB; ld_size = 3;
        tick();
        quiet();
        settle();
        chk("tie_first_we", write_enable, 1);
        chk("tie_first_reg", write_register, 1);
        chk("tie_first_val", write_value, 64'hA);
        tick();
        settle();
        chk("tie_second_we", write_enable, 1);
        chk("tie_second_reg", write_register, 2);
        chk("tie_second_val", write_value, 64'hB);
        tick();
        settle();
        chk("tie_retired", retired_count, 2);
        chk("tie_idle", idle, 1);

        // Load extension table
        foreach (vecs[i]) begin
            ld_valid = 1; ld_rd = vecs[i].rd; ld_data = vecs[i].data;
            ld_size = vecs[i].size; ld_unsigned = vecs[i].uns;
            tick();
            quiet();
            settle();
            chk($sformatf("ldvec%0d_we", i), write_enable, 1);
            chk($sformatf("ldvec%0d_reg", i), write_register, vecs[i].rd);
            chk($sformatf("ldvec%0d_val", i), write_value, vecs[i].exp_value);
            tick();
        end

        // Backpressure: write_ready low for 4 cycles, three ALU entries offered
        do_reset();
        write_ready = 0;
        alu_valid = 1; alu_rd = 1; alu_value = 64'h11;
        settle();
        chk("bp_c0_ready", alu_ready, 1);
        tick();
        alu_rd = 2; alu_value = 64'h22;
        settle();
        chk("bp_c1_ready", alu_ready, 1);
        chk("bp_c1_we", write_enable, 0);
        chk("bp_c1_reg", write_register, 1);
        chk("bp_c1_val", write_value, 64'h11);
        tick();
        alu_rd = 3; alu_value = 64'h33;
        for (int c = 2; c < 4; c++) begin
            settle();
            chk($sformatf("bp_c%0d_ready", c), alu_ready, 0);
            chk($sformatf("bp_c%0d_we", c), write_enable, 0);
            chk($sformatf("bp_c%0d_reg", c), write_register, 1);
            chk($sformatf("bp_c%0d_val", c), write_value, 64'h11);
            tick();
        end
        write_ready = 1;
        settle();
        chk("bp_c4_ready_full", alu_ready, 0);
        chk("bp_c4_we", write_enable, 1);
        chk("bp_c4_reg", write_register, 1);
        tick();
        settle();
        chk("bp_c5_ready", alu_ready, 1);
        chk("bp_c5_we", write_enable, 1);
        chk("bp_c5_val", write_value, 64'h22);
        tick();
        alu_valid = 0;
        settle();
        chk("bp_c6_we", write_enable, 1);
        chk("bp_c6_reg", write_register, 3);
        chk("bp_c6_val", write_value, 64'h33);
        tick();
        settle();
        chk("bp_retired", retired_count, 3);
        chk("bp_idle", idle, 1);

        // Write to x0 is popped but never enabled
        do_reset();
        alu_valid = 1; alu_rd = 0; alu_value = 64'hDEAD;
        tick();
        quiet();
        settle();
        chk("x0_we", write_enable, 0);
        chk("x0_idle_busy", idle, 0);
        tick();
        settle();
        chk("x0_retired", retired_count, 1);
        chk("x0_idle", idle, 1);

        // Reset mid-operation with both FIFOs full
        write_ready = 0;
        alu_valid = 1; alu_rd = 9; alu_value = 64'h99;
        ld_valid = 1; ld_rd = 10; ld_data = 64'h55; ld_size = 3;
        tick();
        tick();
        settle();
        chk("mid_full_alu", alu_ready, 0);
        chk("mid_full_ld", ld_ready, 0);
        quiet();
        reset = 1;
        settle();
        chk("mid_rst_we", write_enable, 0);
        tick();
        reset = 0;
        settle();
        chk("mid_after_idle", idle, 1);
        chk("mid_after_retired", retired_count, 0);
        chk("mid_after_alu_ready", alu_ready, 1);
        chk("mid_after_ld_ready", ld_ready, 1);
        chk("mid_after_we", write_enable, 0);
        chk("mid_after_reg", write_register, 0);

        // Random traffic against a queue-based reference model
        begin
            bit          rr_ld = 1;
            logic [31:0] ret = 0;
            do_reset();
            for (int cyc = 0; cyc < 600; cyc++) begin
                bit          sa, sl, apush, lpush;
                logic [4:0]  er;
                logic [63:0] ev;
                alu_valid   = $urandom_range(0, 1);
                alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_value   = {$urandom, $urandom};
                ld_valid    = $urandom_range(0, 1);
                ld_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ld_data     = {$urandom, $urandom};
                ld_size     = 2'($urandom_range(0, 3));
                ld_unsigned = $urandom_range(0, 1);
                write_ready = ($urandom_range(0, 3) != 0);
                settle();
                sa = (aq.size() > 0) && (lq.size() == 0 || rr_ld);
                sl = (lq.size() > 0) && (aq.size() == 0 || !rr_ld);
                er = sa ? aq[0].rd : (sl ? lq[0].rd : 5'd0);
                ev = sa ? aq[0].v : (sl ? lq[0].v : 64'd0);
                chk("rnd_we", write_enable, (sa || sl) && write_ready && er != 0);
                chk("rnd_reg", write_register, er);
                chk("rnd_val", write_value, ev);
                chk("rnd_alu_ready", alu_ready, aq.size() < DEPTH);
                chk("rnd_ld_ready", ld_ready, lq.size() < DEPTH);
                chk("rnd_idle", idle, aq.size() == 0 && lq.size() == 0);
                chk("rnd_retired", retired_count, ret);
                apush = alu_valid && aq.size() < DEPTH;
                lpush = ld_valid && lq.size() < DEPTH;
                if (write_ready && sa) begin void'(aq.pop_front()); rr_ld = 0; ret++; end
                if (write_ready && sl) begin void'(lq.pop_front()); rr_ld = 1; ret++; end
                if (apush) aq.push_back('{alu_rd, alu_value});
                if (lpush) lq.push_back('{ld_rd, ref_extend(ld_data, int'(ld_size), ld_unsigned)});
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
